// File: rtl/mcpu_alu_issuer.sv
// Initiator side of the MCPU ALU interface: accepts an instruction, reads operands from a
// small register file, drives a combinational ALU, and writes the result back two edges later.
module mcpu_alu_issuer #(
    parameter int CMD_SIZE  = 2,
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [CMD_SIZE-1:0]  instr_cmd,
    input  logic [ADDR_SIZE-1:0] instr_rd,
    input  logic [ADDR_SIZE-1:0] instr_rs1,
    input  logic [ADDR_SIZE-1:0] instr_rs2,
    input  logic                 ld_en,
    input  logic [ADDR_SIZE-1:0] ld_addr,
    input  logic [WORD_SIZE-1:0] ld_data,
    output logic [CMD_SIZE-1:0]  alu_cmd,
    output logic [WORD_SIZE-1:0] alu_in1,
    output logic [WORD_SIZE-1:0] alu_in2,
    input  logic [WORD_SIZE-1:0] alu_out,
    input  logic                 alu_cf,
    output logic                 res_valid,
    output logic [WORD_SIZE-1:0] res_data,
    output logic                 res_cf
);

    // state   | meaning
    // IDLE    | ready for an instruction
    // ISSUE   | operands and opcode driven to the ALU
    // CAPTURE | ALU result written back on the edge leaving this state
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    localparam int NUM_REGS = 1 << ADDR_SIZE;
    localparam logic [CMD_SIZE-1:0] CMD_ADD = CMD_SIZE'(3);

    state_t state, state_nxt;
    logic   accept;
    logic   wb_en;

    logic [WORD_SIZE-1:0] regs [NUM_REGS];
    logic [ADDR_SIZE-1:0] rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = S_ISSUE;
            S_ISSUE:   state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == S_IDLE);
        accept      = instr_ready && instr_valid;
        wb_en       = (state == S_CAPTURE);
    end

    // Operands are sampled from the pre-edge register contents, so a host load on the
    // accept edge is not visible to this instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_cmd <= '0;
            alu_in1 <= '0;
            alu_in2 <= '0;
            rd_q    <= '0;
        end else if (accept) begin
            alu_cmd <= instr_cmd;
            alu_in1 <= regs[instr_rs1];
            alu_in2 <= regs[instr_rs2];
            rd_q    <= instr_rd;
        end
    end

    // Writeback has priority over a host load to the same register on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wb_en && (rd_q == ADDR_SIZE'(i))) begin
                    regs[i] <= alu_out;
                end else if (ld_en && (ld_addr == ADDR_SIZE'(i))) begin
                    regs[i] <= ld_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_cf    <= 1'b0;
        end else begin
            res_valid <= wb_en;
            if (wb_en) begin
                res_data <= alu_out;
                res_cf   <= (alu_cmd == CMD_ADD) ? alu_cf : 1'b0;
            end
        end
    end

endmodule
